// File: rtl/elevator_motion_ctrl_if.sv
// Request handshake between the floor-request queue (master) and the
// elevator motion controller (slave). A request is transferred on any rising
// clock edge where req_valid and req_ready are both high.
interface elevator_motion_ctrl_if #(
    parameter int FLOOR_W = 3
) ();
    logic               req_valid;
    logic [FLOOR_W-1:0] req_floor;
    logic               req_ready;

    modport master (output req_valid, output req_floor, input req_ready);
    modport slave  (input req_valid, input req_floor, output req_ready);
endinterface

// File: rtl/elevator_motion_ctrl.sv
// Elevator car motion sequencer. Takes one target floor at a time, steps the
// car one floor per travel delay, then holds the door open for a dwell delay.
// All delays are timed by an external delay timer that this block starts and
// whose registered finished flag it consumes. Every output is registered.
module elevator_motion_ctrl #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = 3,
    parameter int TICK_W       = 28,
    parameter int TRAVEL_TICKS = 50_000_000,
    parameter int DOOR_TICKS   = 150_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    elevator_motion_ctrl_if.slave req,
    output logic                tmr_start,
    output logic [TICK_W-1:0]   tmr_count,
    input  logic                tmr_finished,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                moving_up,
    output logic                moving_down,
    output logic                door_open,
    output logic                done_pulse,
    output logic                err_pulse
);

    localparam logic [TICK_W-1:0] TRAVEL_CNT = TICK_W'(TRAVEL_TICKS);
    localparam logic [TICK_W-1:0] DOOR_CNT   = TICK_W'(DOOR_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR,
        GAP
    } state_t;

    state_t             state;
    logic               arm;            // 1 = ARM cycle of a delay, finished flag is stale
    logic               go_up;          // travel direction of the current request
    logic               gap_from_door;  // the GAP in progress follows the door dwell
    logic [FLOOR_W-1:0] target;

    // Single sequencer: state, position and every registered output.
    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, no matter the order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            arm           <= 1'b0;
            go_up         <= 1'b0;
            gap_from_door <= 1'b0;
            target        <= '0;
            cur_floor     <= '0;
            req.req_ready <= 1'b0;
            tmr_start     <= 1'b0;
            tmr_count     <= '0;
            moving_up     <= 1'b0;
            moving_down   <= 1'b0;
            door_open     <= 1'b0;
            done_pulse    <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    req.req_ready <= 1'b1;
                    if (req.req_valid && req.req_ready) begin
                        target <= req.req_floor;
                        if (32'(req.req_floor) >= NUM_FLOORS) begin
                            // Out-of-range request: consume it and stay ready.
                            err_pulse <= 1'b1;
                        end else if (req.req_floor == cur_floor) begin
                            req.req_ready <= 1'b0;
                            state         <= DOOR;
                            arm           <= 1'b1;
                            tmr_start     <= 1'b1;
                            tmr_count     <= DOOR_CNT;
                            door_open     <= 1'b1;
                        end else begin
                            req.req_ready <= 1'b0;
                            state         <= MOVE;
                            arm           <= 1'b1;
                            go_up         <= (req.req_floor > cur_floor);
                            tmr_start     <= 1'b1;
                            tmr_count     <= TRAVEL_CNT;
                            moving_up     <= (req.req_floor > cur_floor);
                            moving_down   <= (req.req_floor < cur_floor);
                        end
                    end
                end

                MOVE, DOOR: begin
                    if (arm) begin
                        // The timer may still show the previous delay's flag.
                        arm <= 1'b0;
                    end else if (tmr_finished) begin
                        state         <= GAP;
                        gap_from_door <= (state == DOOR);
                        tmr_start     <= 1'b0;
                        tmr_count     <= '0;
                        moving_up     <= 1'b0;
                        moving_down   <= 1'b0;
                        door_open     <= 1'b0;
                        if (state == MOVE) begin
                            cur_floor <= go_up ? cur_floor + 1'b1 : cur_floor - 1'b1;
                        end
                    end
                end

                GAP: begin
                    // One idle cycle lets the timer return to zero.
                    if (gap_from_door) begin
                        state         <= IDLE;
                        req.req_ready <= 1'b1;
                        done_pulse    <= 1'b1;
                    end else if (cur_floor != target) begin
                        state       <= MOVE;
                        arm         <= 1'b1;
                        tmr_start   <= 1'b1;
                        tmr_count   <= TRAVEL_CNT;
                        moving_up   <= go_up;
                        moving_down <= !go_up;
                    end else begin
                        state     <= DOOR;
                        arm       <= 1'b1;
                        tmr_start <= 1'b1;
                        tmr_count <= DOOR_CNT;
                        door_open <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench for elevator_motion_ctrl. Stimulus pushes the expected
// delay/done/error events; a negedge monitor turns DUT activity into events
// and pops/compares them.
module tb_elevator_motion_ctrl;

    localparam int NUM_FLOORS   = 8;
    localparam int FLOOR_W      = 4;
    localparam int TICK_W       = 28;
    localparam int TRAVEL_TICKS = 3;
    localparam int DOOR_TICKS   = 5;

    // kind: 0 = completed delay, 1 = done pulse, 2 = error pulse
    typedef struct packed {
        logic [1:0]         kind;
        logic [2:0]         flags;  // {moving_up, moving_down, door_open} over the delay
        logic [7:0]         aux;    // delay length, or cycles since delay end for done
        logic [7:0]         cnt;    // tmr_count seen during the delay
        logic [FLOOR_W-1:0] floor;
        logic               rdy;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elevator_motion_ctrl_if #(.FLOOR_W(FLOOR_W)) req_if ();

    logic               tmr_start;
    logic [TICK_W-1:0]  tmr_count;
    logic               tmr_finished = 1'b0;
    logic [FLOOR_W-1:0] cur_floor;
    logic               moving_up, moving_down, door_open, done_pulse, err_pulse;

    elevator_motion_ctrl #(
        .NUM_FLOORS  (NUM_FLOORS),
        .FLOOR_W     (FLOOR_W),
        .TICK_W      (TICK_W),
        .TRAVEL_TICKS(TRAVEL_TICKS),
        .DOOR_TICKS  (DOOR_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_if),
        .tmr_start   (tmr_start),
        .tmr_count   (tmr_count),
        .tmr_finished(tmr_finished),
        .cur_floor   (cur_floor),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .done_pulse  (done_pulse),
        .err_pulse   (err_pulse)
    );

    // Behavioural delay timer: finished rises after count+1 cycles of start.
    // Pulse mode drops it again a cycle later; hold mode keeps it high so the
    // next delay's ARM cycle sees a stale flag. Start low freezes the flag.
    logic hold_mode = 1'b0;
    int   tcnt = 0;
    always @(posedge clk) begin
        if (tmr_start) begin
            if (hold_mode) tmr_finished <= (tcnt >= int'(tmr_count));
            else           tmr_finished <= (tcnt == int'(tmr_count));
            if (tcnt <= int'(tmr_count)) tcnt <= tcnt + 1;
        end else begin
            tcnt <= 0;
        end
    end

    int   tests = 0;
    int   fails = 0;
    int   viol = 0;
    int   model_floor = 0;
    ev_t  sb[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic ev_t mk_ev(int kind, logic [2:0] flags, int aux, int cnt, int floor, logic rdy);
        ev_t e;
        e.kind  = 2'(kind);
        e.flags = flags;
        e.aux   = 8'(aux);
        e.cnt   = 8'(cnt);
        e.floor = FLOOR_W'(floor);
        e.rdy   = rdy;
        return e;
    endfunction

    task automatic sb_compare(ev_t got);
        ev_t exp;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL event_unexpected: got %p, expected no event", got);
        end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
                fails++;
                $display("FAIL event: got %p, expected %p", got, exp);
            end
        end
    endtask

    // Monitor: builds events from DUT outputs on the falling edge.
    int                dlen = 0, low_run = 0, since_fall = 0;
    logic [2:0]        f_or, f_and, flags_now;
    logic [TICK_W-1:0] first_cnt;
    logic              cnt_bad, prev_start = 1'b0, prev_rdy = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            dlen = 0; low_run = 0; since_fall = 0;
            prev_start = 1'b0; prev_rdy = 1'b0;
        end else begin
            flags_now = {moving_up, moving_down, door_open};
            if ($countones(flags_now) > 1) viol++;
            if (!tmr_start && (tmr_count != '0 || flags_now != 3'b000)) viol++;
            if (err_pulse && tmr_start) viol++;

            if (tmr_start && !prev_start) begin
                if (!prev_rdy) check("gap_len", low_run, 1);
                dlen = 0; f_or = 3'b000; f_and = 3'b111;
                first_cnt = tmr_count; cnt_bad = 1'b0;
            end
            if (tmr_start) begin
                dlen++;
                f_or  = f_or | flags_now;
                f_and = f_and & flags_now;
                if (tmr_count != first_cnt) cnt_bad = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end

            if (!tmr_start && prev_start) begin
                since_fall = 0;
                sb_compare(mk_ev(0, (f_or == f_and && !cnt_bad) ? f_or : 3'b111,
                                 dlen, int'(first_cnt), int'(cur_floor), req_if.req_ready));
            end else if (since_fall < 255) begin
                since_fall++;
            end
            if (done_pulse) sb_compare(mk_ev(1, 3'b000, since_fall, 0, int'(cur_floor), req_if.req_ready));
            if (err_pulse)  sb_compare(mk_ev(2, 3'b000, 0, 0, int'(cur_floor), req_if.req_ready));

            prev_start = tmr_start;
            prev_rdy   = req_if.req_ready;
        end
    end

    // Issue one request and queue the events it should produce.
    task automatic send(int f);
        for (int i = 0; i < 200 && !req_if.req_ready; i++) @(negedge clk);
        check("ready_wait", req_if.req_ready, 1);
        if (f >= NUM_FLOORS) begin
            sb.push_back(mk_ev(2, 3'b000, 0, 0, model_floor, 1'b1));
        end else begin
            while (model_floor != f) begin
                if (f > model_floor) begin
                    model_floor++;
                    sb.push_back(mk_ev(0, 3'b100, TRAVEL_TICKS + 2, TRAVEL_TICKS, model_floor, 1'b0));
                end else begin
                    model_floor--;
                    sb.push_back(mk_ev(0, 3'b010, TRAVEL_TICKS + 2, TRAVEL_TICKS, model_floor, 1'b0));
                end
            end
            sb.push_back(mk_ev(0, 3'b001, DOOR_TICKS + 2, DOOR_TICKS, f, 1'b0));
            sb.push_back(mk_ev(1, 3'b000, 1, 0, f, 1'b1));
        end
        req_if.req_valid = 1'b1;
        req_if.req_floor = FLOOR_W'(f);
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
    endtask

    task automatic wait_drain(string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check(name, sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(string name);
        check({name, "_flags"}, {req_if.req_ready, tmr_start, moving_up, moving_down,
                                 door_open, done_pulse, err_pulse}, 0);
        check({name, "_floor"}, cur_floor, 0);
        check({name, "_count"}, tmr_count, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_before_edge", req_if.req_ready, 0);
        @(posedge clk);
        #1 check("ready_first_edge", req_if.req_ready, 1);
        check("floor_after_reset", cur_floor, 0);
    endtask

    initial begin
        req_if.req_valid = 1'b0;
        req_if.req_floor = '0;
        #12 check_all_zero("reset");
        release_reset();

        send(3); wait_drain("drain_up_to_3");
        send(1); wait_drain("drain_down_to_1");
        send(2); wait_drain("drain_up_to_2");
        send(2); wait_drain("drain_same_floor");

        send(9); wait_drain("drain_err");
        check("err_floor", cur_floor, model_floor);
        check("err_ready", req_if.req_ready, 1);

        hold_mode = 1'b1;
        send(0); wait_drain("drain_stale_finished");

        hold_mode = 1'b0;
        send(5);
        for (int i = 0; i < 200 && !(cur_floor == 2 && moving_up); i++) @(negedge clk);
        check("reach_floor2_moving", {cur_floor, moving_up}, {4'd2, 1'b1});
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        sb.delete();
        model_floor = 0;
        repeat (2) @(negedge clk);
        release_reset();

        send(1); wait_drain("drain_after_reset");

        check("invariants", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/elevator_motion_ctrl.md
# elevator_motion_ctrl

Car motion sequencer for the Spartan Elevator: accepts one target-floor request at a time from the request queue. It steps the car floor by floor, opens the door, and reports completion. It contains no timing counters of its own. It is the initiator side of the team's delay-timer interface: it drives start/count and consumes the timer's registered finished flag.

## Interface
- NUM_FLOORS, 8, number of floors (floor indices 0..NUM_FLOORS-1)
- FLOOR_W, 3, width of floor indices; must satisfy 2^FLOOR_W >= NUM_FLOORS
- TICK_W, 28, width of the timer count bus
- TRAVEL_TICKS, 50_000_000, delay count for one floor of travel (1 s at 50 MHz)
- DOOR_TICKS, 150_000_000, delay count for the door-open dwell

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  queue presents a request
- req_floor  in  FLOOR_W  target floor of the request
- req_ready  out  1  controller can accept; high only in IDLE
- tmr_start  out  1  delay-timer enable, held high for the whole delay
- tmr_count  out  TICK_W  delay target; stable whenever tmr_start=1
- tmr_finished  in  1  registered completion flag from the delay timer
- cur_floor  out  FLOOR_W  current car position
- moving_up  out  1  high during an upward travel delay
- moving_down  out  1  high during a downward travel delay
- door_open  out  1  high during the door dwell
- done_pulse  out  1  one-cycle pulse when a request completes
- err_pulse  out  1  one-cycle pulse when an out-of-range request is consumed

## Operation
- States: IDLE, MOVE, DOOR, GAP. Each delay inside MOVE or DOOR has two sub-phases:
  - ARM: exactly 1 cycle; tmr_start=1; tmr_finished is ignored.
  - WAIT: tmr_start=1; the delay completes on the first cycle tmr_finished=1 is sampled.
- ARM is mandatory because the timer's finished flag holds its last value while start is low. The first sample after start rises can be stale.
- IDLE: req_ready=1. On req_valid & req_ready, target <= req_floor.
  - req_floor >= NUM_FLOORS: request is consumed; err_pulse is asserted the next cycle; state stays IDLE. err_pulse and req_ready are both high in that cycle, so a new request may be accepted then.
  - req_floor == cur_floor: go to DOOR.
  - otherwise: go to MOVE, with direction set by target > cur_floor.
- MOVE: tmr_count=TRAVEL_TICKS. moving_up or moving_down is high per direction for all of ARM+WAIT.
  - On completion: cur_floor +/-1, then GAP.
  - After GAP: back to MOVE if cur_floor != target, else to DOOR.
- DOOR: tmr_count=DOOR_TICKS, door_open=1. On completion: GAP, then IDLE, with done_pulse=1 in the first IDLE cycle.
- GAP: exactly 1 cycle with tmr_start=0. The timer returns to zero before the next delay starts.
- tmr_count is 0 whenever tmr_start=0.
- moving_up, moving_down, and door_open are mutually exclusive.
- cur_floor never wraps: it is bounded to 0..NUM_FLOORS-1 by construction, since target is range-checked.
- req_valid is ignored outside IDLE. The queue must hold its request until it sees req_ready.
- The controller makes no assumption about timer latency. A timer that never finishes stalls the controller in WAIT indefinitely; there is no watchdog in this block.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, cur_floor=0, target=0
  - req_ready=0, tmr_start=0, tmr_count=0
  - moving_up=0, moving_down=0, door_open=0, done_pulse=0, err_pulse=0
- req_ready rises on the first clk edge after rst_n deasserts.
- Reset mid-operation aborts immediately and loses the car position (cur_floor=0). Floor re-homing is the supervisor's job.
- Acceptance edge to first ARM cycle: 1 cycle. req_ready falls in the cycle after acceptance.
- All outputs are registered; none are combinational from inputs.
- Per floor step: 1 (ARM) + N (WAIT, N>=1 timer-dependent) + 1 (GAP) cycles.
- cur_floor updates on the edge that samples tmr_finished=1 in MOVE/WAIT.
- done_pulse and the return of req_ready=1 occur in the same cycle, 2 cycles after finished is sampled in DOOR/WAIT.

## Test plan
Bench parameters: TRAVEL_TICKS=3, DOOR_TICKS=5. The bench uses a behavioural timer model that asserts finished for 1 cycle after count+1 cycles of start, and holds it while start is low.

- Reset, then request floor 3 -> three MOVE delays with moving_up=1 and cur_floor 0->1->2->3; one DOOR delay with door_open=1; done_pulse exactly once; tmr_start low for 1 cycle between delays.
- From floor 3, request floor 1 -> moving_down only, cur_floor 3->2->1, then DOOR, then done_pulse.
- Request floor equal to cur_floor (2 at 2) -> no MOVE, DOOR immediately, done_pulse; moving_up and moving_down stay 0.
- Request floor 9 (NUM_FLOORS=8) -> consumed, err_pulse for 1 cycle, no tmr_start, cur_floor unchanged, req_ready stays high.
- Timer model leaves finished=1 from the previous delay -> controller ignores it in ARM and does not advance cur_floor until the fresh finished pulse.
- Assert rst_n=0 mid-travel at floor 2 heading to 5 -> all outputs 0 asynchronously; after release, cur_floor=0 and req_ready=1 on the first edge.
